// File: rtl/twosc_pkg.sv
// twosc_pkg -- shared definitions for the serial two's-complement negator.
//   TWOSC_W_DEF   : default word width
//   twosc_state_e : sequencer FSM states (IDLE, SHIFT, HOLD)
package twosc_pkg;

  localparam int TWOSC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } twosc_state_e;

endpackage

// File: rtl/twosc_cell.sv
// twosc_cell -- serial two's-complement bit cell, LSB first.
//   clk, r    : clock, async active-high reset
//   clr       : clear the "first one seen" flag before a new word
//   en        : a bit is being processed this cycle
//   bit_in    : operand bit
//   bit_out   : negated bit (copy until the first 1 has passed, invert after)
module twosc_cell (
  input  logic clk,
  input  logic r,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic bit_out
);

  logic found_q, found_d;

  always_comb begin
    found_d = found_q;
    if (clr)     found_d = 1'b0;
    else if (en) found_d = found_q | bit_in;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) found_q <= 1'b0;
    else   found_q <= found_d;
  end

  assign bit_out = found_q ? ~bit_in : bit_in;

endmodule

// File: rtl/twosc_word_seq.sv
// twosc_word_seq -- negates a W-bit two's-complement word by streaming it
// LSB-first through twosc_cell, one bit per cycle.
//   clk, r               : clock, async active-high reset
//   in_valid/in_ready    : operand handshake (accepted only in IDLE)
//   in_data              : operand
//   out_valid/out_ready  : result handshake (result held in HOLD)
//   out_data             : negated operand, updated only on entry to HOLD
//   busy                 : high in SHIFT and HOLD
//   out_ovf              : only with TWOSC_OVF_FLAG_EN; operand was the
//                          most-negative value (negation wrapped)
module twosc_word_seq
  import twosc_pkg::*;
#(
  parameter int W = TWOSC_W_DEF
) (
  input  logic         clk,
  input  logic         r,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef TWOSC_OVF_FLAG_EN
  output logic         out_ovf,
`endif
  output logic         busy
);

  localparam int CW = $clog2(W) + 1;

  twosc_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  out_q, out_d;
  logic [W-1:0]  res_next;
  logic          cell_clr, cell_en, cell_bit;
  logic          last_bit;

  twosc_cell u_cell (
    .clk     (clk),
    .r       (r),
    .clr     (cell_clr),
    .en      (cell_en),
    .bit_in  (sh_q[0]),
    .bit_out (cell_bit)
  );

  // Result enters at the MSB end so after W shifts bit 0 lands at index 0.
  assign res_next = {cell_bit, res_q[W-1:1]};
  assign last_bit = (cnt_q == CW'(W - 1));

`ifdef TWOSC_OVF_FLAG_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    res_d    = res_q;
    out_d    = out_q;
    cell_clr = 1'b0;
    cell_en  = 1'b0;
`ifdef TWOSC_OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d     = in_data;
          cnt_d    = '0;
          cell_clr = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        cell_en = 1'b1;
        sh_d    = sh_q >> 1;
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          out_d   = res_next;
          state_d = HOLD;
`ifdef TWOSC_OVF_FLAG_EN
          // Output equals a 1 input only while no earlier 1 was seen, so a 1
          // passing through unchanged at the MSB means "first one at W-1".
          ovf_d = sh_q[0] & cell_bit;
`endif
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
`ifdef TWOSC_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      out_q   <= out_d;
`ifdef TWOSC_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;
`ifdef TWOSC_OVF_FLAG_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_twosc_word_seq.sv
// tb_twosc_word_seq -- randomized/directed bench for twosc_word_seq (W=8).
// Expected results come from plain arithmetic negation modulo 2^W.
module tb_twosc_word_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef TWOSC_OVF_FLAG_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_res = '0;

  always #5 clk = ~clk;

  twosc_word_seq #(.W(W)) dut (
    .clk       (clk),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef TWOSC_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] neg(input logic [W-1:0] d);
    logic [W:0] m;
    m = (W+1)'(1) << W;
    return W'(m - {1'b0, d});
  endfunction

  // Offer one word, measure latency, stall `hold` cycles in HOLD while
  // offering a competing word, then release.
  task automatic send_word(input logic [W-1:0] d, input int hold);
    logic [W-1:0] exp;
    int lat;
    bit seen;
    exp = neg(d);
    @(negedge clk);
    chk("rdy_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) seen = 1;
      else chk("data_before_hold", 32'(out_data), 32'(prev_res));
    end
    chk("latency", lat, W);
    chk("data", 32'(out_data), 32'(exp));
    chk("busy_hold", 32'(busy), 1);
    chk("rdy_hold", 32'(in_ready), 0);
`ifdef TWOSC_OVF_FLAG_EN
    chk("ovf", 32'(out_ovf), 32'(d == (W'(1) << (W-1))));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      @(posedge clk);
      @(negedge clk);
      chk("stall_vld", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(exp));
      chk("stall_rdy", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("rel_vld", 32'(out_valid), 0);
    chk("rel_rdy", 32'(in_ready), 1);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_data", 32'(out_data), 32'(exp));
    prev_res = exp;
  endtask

  initial begin
    logic [W-1:0] q[$];
    int outs, pushed, last_cyc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    r = 1'b0;

    // Directed values incl. boundaries
    send_word(8'h05, 0);
    send_word(8'h00, 0);
    send_word(8'h01, 1);
    send_word(8'h7F, 0);
    send_word(8'h80, 2);
    send_word(8'hFF, 0);
    send_word(8'h05, 5);

    // Random words with random stalls
    for (int i = 0; i < 10; i++) send_word(W'($urandom), int'($urandom_range(0, 3)));

    // Reset in the middle of SHIFT: word discarded immediately
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    r = 1'b1;
    #1;
    chk("midrst_rdy", 32'(in_ready), 1);
    chk("midrst_vld", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", 32'(out_data), 0);
    @(negedge clk);
    r = 1'b0;
    prev_res = '0;
    send_word(8'h05, 0);

    // Back-to-back with out_ready held high: one result per W+2 cycles
    out_ready = 1'b1;
    outs = 0;
    pushed = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 200 && outs < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) chk("b2b_extra", 32'(out_data), 32'hFFFF_FFFF);
        else chk("b2b_data", 32'(out_data), 32'(neg(q.pop_front())));
        if (last_cyc >= 0) chk("b2b_interval", cyc - last_cyc, W + 2);
        last_cyc = cyc;
        outs++;
      end
      if (in_ready && pushed < 6) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        q.push_back(in_data);
        pushed++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    chk("b2b_count", outs, 6);
    chk("b2b_left", q.size(), 0);
    @(negedge clk);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twosc_word_seq.md
TWOSC_WORD_SEQ -- requirements
Module: twosc_word_seq

Interface
REQ-001 SHALL have parameter W, default 8, word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port r, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, parallel input word offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept a word.
REQ-006 SHALL have port in_data, input, W, two's-complement operand.
REQ-007 SHALL have port out_valid, output, 1, result word available.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-009 SHALL have port out_data, output, W, negated operand (two's complement of in_data).
REQ-010 SHALL have port busy, output, 1, high in SHIFT and HOLD states.

Function
REQ-011 SHALL sequence one serial two's-complement cell LSB-first: cell output = found ? ~bit : bit, then found |= bit.
REQ-012 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-013 IDLE: in_ready=1; on in_valid at edge, load in_data into shift register, clear cell found flag, clear bit counter, go SHIFT.
REQ-014 SHIFT: in_ready=0; one bit per cycle through the cell, result bit shifted into result register MSB-end; counter increments.
REQ-015 SHIFT SHALL last exactly W cycles; on the edge processing bit W-1, go HOLD.
REQ-016 HOLD: out_valid=1, out_data stable; on out_ready at edge, go IDLE; out_valid=0 on the following cycle.
REQ-017 Latency: word accepted at edge k SHALL yield out_valid=1 after edge k+W.
REQ-018 in_ready SHALL be 0 in SHIFT and HOLD; in_valid there SHALL be ignored and the upstream word not consumed.
REQ-019 out_ready outside HOLD SHALL be ignored.
REQ-020 out_data SHALL hold its last result in IDLE and SHIFT; it SHALL update only on the transition into HOLD.
REQ-021 Boundary: input 0 -> 0; input 1 -> all-ones; input 100..0 -> 100..0 (wraps, no saturation).
REQ-022 Counter SHALL be $clog2(W)+1 bits; no wrap within a word.
REQ-023 Maximum throughput: one word per W+2 cycles with out_ready held high.

Reset
REQ-024 r high SHALL immediately force state IDLE, counter 0, found 0, shift/result registers 0.
REQ-025 Reset values: in_ready=1, out_valid=0, out_data=0, busy=0 (and out_ovf=0 when enabled).
REQ-026 Reset mid-SHIFT or mid-HOLD SHALL discard the word in flight; no partial result emitted.
REQ-027 First accept after reset release SHALL occur at the first edge with r=0 and in_valid=1.

Configuration
REQ-028 Macro TWOSC_OVF_FLAG_EN SHALL add output out_ovf, 1 bit, valid with out_valid.
REQ-029 With TWOSC_OVF_FLAG_EN, out_ovf=1 iff operand was most-negative (MSB 1, rest 0), detected serially (first 1 seen at bit W-1).
REQ-030 Without TWOSC_OVF_FLAG_EN, port out_ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package twosc_pkg SHALL hold the FSM state enum (IDLE, SHIFT, HOLD) and default width constant TWOSC_W_DEF=8.
REQ-032 Sub-module twosc_cell SHALL implement the serial bit cell: inputs clk, r, clr, en, bit_in; output bit_out.
REQ-033 twosc_word_seq SHALL own FSM, counter, shift/result registers, and handshakes.

Verification
REQ-034 W=8, in_data=0x05 -> out_data=0xFB, out_valid 8 cycles after accept.
REQ-035 in_data=0x00 -> 0x00; in_data=0x01 -> 0xFF; in_data=0x7F -> 0x81.
REQ-036 in_data=0x80 -> out_data=0x80; out_ovf=1 with TWOSC_OVF_FLAG_EN; port absent without it.
REQ-037 out_ready=0 for 5 cycles in HOLD -> out_data/out_valid stable; in_ready=0; second in_valid not consumed until after release.
REQ-038 r pulsed at SHIFT cycle 3 -> immediate IDLE, out_valid=0, in_ready=1; next word 0x05 -> 0xFB correct.
REQ-039 Back-to-back words with out_ready=1 -> one result per 10 cycles, no lost or duplicated words.
